// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing helper for the bit-serial adder/subtractor.
// Imported by the top level; holds no logic.
package serial_adder_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // The counter has to hold 0..WIDTH, so it needs one more code than the bit count.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational 1-bit full adder: the only arithmetic cell of the serial datapath.
// Zero latency; no flow control.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract, LSB first; result, carry and overflow appear WIDTH+1 edges after start.
// start is only accepted in IDLE (including the done cycle); requests while busy are dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             cmsb;
  logic             s_bit;
  logic             c_nxt;
  logic             load;
  logic             step;
  logic             last;
  logic             pre_msb;

  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign pre_msb = (cnt == CNT_W'(WIDTH - 2));

  fa_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c),
    .s    (s_bit),
    .cout (c_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    step = 1'b0;
    case (state)
      S_IDLE:  load = start;
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      a_sr <= '0;
      b_sr <= '0;
      res  <= '0;
      c    <= 1'b0;
      cmsb <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Subtract becomes a + ~b + 1: invert B here and seed the carry with 1.
        a_sr <= a;
        b_sr <= sub ? ~b : b;
        c    <= sub | cin;
        cnt  <= '0;
        cmsb <= 1'b0;
      end else if (step) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        res  <= {s_bit, res[WIDTH-1:1]};
        c    <= c_nxt;
        cnt  <= cnt + CNT_W'(1);
        // Carry out of bit WIDTH-2 is the carry into the sign bit.
        if (pre_msb) begin
          cmsb <= c_nxt;
        end
        if (last) begin
          sum  <= {s_bit, res[WIDTH-1:1]};
          cout <= c_nxt;
          ovf  <= cmsb ^ c_nxt;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor. Processes WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Generalises the combinational 1-bit full adder to N bits, adds a subtract mode and a signed-overflow flag, and uses a start/busy/done handshake.
- Serves as the area-minimal arithmetic unit for the lab datapath, driven by a simple controller.

Parameters:
- WIDTH, 8, operand and result width in bits; WIDTH >= 2.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived, not overridden).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when idle.
- sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result; valid from done, held until the next completion.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed (two's complement) overflow.

Behaviour:
- Clocking/reset: one clock, clk; rst is synchronous and active-high.
- While rst=1 at an edge:
  - state goes to IDLE;
  - busy, done, sum, cout, ovf, counter, shift registers and carry flop all go to 0.
- States: IDLE, RUN.
- IDLE:
  - If start=1 at an edge, load shift registers with A=a and B=(sub ? ~b : b).
  - Load carry flop with (sub ? 1 : cin), counter=0, busy<=1, go to RUN.
  - Otherwise hold.
- RUN, each edge:
  - s = A[0]^B[0]^c; c_next = majority(A[0],B[0],c).
  - Shift A and B right.
  - Shift s into the MSB of the internal result register.
  - c <= c_next; counter++.
  - Before the MSB step (counter==WIDTH-1), latch the carry-into-MSB into cmsb.
- Completion, at the edge processing bit WIDTH-1:
  - sum <= final result register contents, including that bit;
  - cout <= c_next;
  - ovf <= cmsb ^ c_next;
  - done <= 1, busy <= 0, state goes to IDLE.
- Latency: if start is sampled at edge n, busy is high from edge n to edge n+WIDTH. done is high exactly for the cycle following edge n+WIDTH (WIDTH+1 edges from request to a visible result).
- done: high for exactly one cycle, cleared at the next edge unless a new completion occurs.
- start while busy=1: ignored, with no effect on operands or timing.
- start in the done cycle: accepted, because the state is IDLE. This gives back-to-back throughput of one result per WIDTH+1 cycles.
- sum/cout/ovf: change only at a completion edge or on reset, never during RUN.
- Operand inputs (a, b, sub, cin): may change freely after the start edge.
- Reset mid-RUN: the operation is aborted, no done pulse, outputs are 0, and the block is in IDLE on the next cycle.
- Arithmetic: result is modulo 2^WIDTH. Subtract is implemented as a + ~b + 1.

Decomposition:
- serial_adder_pkg:
  - state encoding constants S_IDLE=1'b0, S_RUN=1'b1;
  - counter-width helper function.
- One sub-module: fa_bit, a combinational 1-bit full adder (a, b, cin -> s, cout), instantiated once.
- Top level contains the FSM, counter, shift registers, carry flop and output registers.

Test Plan:
- Reset check: assert rst for 2 cycles mid-idle -> busy=0, done=0, sum=0x00, cout=0, ovf=0.
- Add (WIDTH=8): a=0x3C, b=0x0F, cin=0, sub=0, start at edge n -> done high after edge n+8 only, sum=0x4B, cout=0, ovf=0; busy high for exactly 8 cycles.
- Carry chain: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- Subtract: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Handshake:
  - start held high throughout -> exactly one operation per 9 cycles;
  - changing a/b during RUN does not alter the result;
  - start in the done cycle launches the next operation.
- Abort: rst asserted at the 3rd RUN cycle of a=0xAA, b=0x55 -> busy=0 next cycle, no done pulse, sum=0x00. A subsequent start of 0x01+0x01 yields sum=0x02 normally.
